frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Instruction sequencer for the oak832128 execute core. Owns the program counter, fetches 17-bit instruction frames from program memory over a request/valid interface, and resolves control frames itself: JMP, JNE, JEQ and HALT. Data frames (opcodes 0x0–0xB) are issued to the execute core over a valid/ready handshake. It replaces free-running `pc` increment with a real fetch/decode/issue loop.

## Interface
Parameters:
- `RESET_PC`, 8'h00: PC value loaded on reset.
- `FETCH_TIMEOUT`, 15: max cycles `imem_req` may stay high without `imem_rvalid`. 0 disables the watchdog.

Ports:
- `sysclk`: in, 1. Single clock; all logic on posedge.
- `reset_n`: in, 1. Synchronous reset, active low.
- `run`: in, 1. Level; sequencing proceeds while high.
- `imem_req`: out, 1. Fetch request.
- `imem_addr`: out, 8. Fetch address (= `pc`).
- `imem_rdata`: in, 17. Frame; valid with `imem_rvalid`.
- `imem_rvalid`: in, 1. Fetch response, ≥1 cycle after request.
- `frame`: out, 17. Frame to execute core.
- `frame_valid`: out, 1. Frame offered.
- `frame_ready`: in, 1. Core accepts frame.
- `zero_flag`: in, 1. Core result-zero flag from last accepted frame.
- `pc`: out, 8. Current program counter.
- `halted`: out, 1. HALT frame executed.
- `fault`: out, 1. Fetch watchdog expired.

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, HALT.
- IDLE: go to FETCH when `run`=1 (or on `step` pulse, see Configuration).
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_rvalid`. On `imem_rvalid`, latch `imem_rdata` into the frame register and go to DECODE. `imem_rvalid` outside FETCH is ignored.
- DECODE: classify by `frame[16:13]`:
  - 0x0–0xB: go to ISSUE.
  - 0xC JMP: `pc`←`frame[12:5]`.
  - 0xD JNE: `pc`←`frame[12:5]` if `zero_flag`=0, else `pc`+1.
  - 0xE JEQ: `pc`←`frame[12:5]` if `zero_flag`=1, else `pc`+1.
  - 0xF: go to HALT.
  - After a JMP/JNE/JEQ, go to FETCH if `run`, else IDLE. Control frames are never presented on `frame`.
- ISSUE: `frame_valid`=1 and `frame` held stable until `frame_ready`. On the handshake, `pc`←`pc`+1, then go to FETCH if `run`, else IDLE.
- HALT: `halted`=1. Exit only via reset.
- Watchdog: counts cycles in FETCH. When the count reaches `FETCH_TIMEOUT`, assert `fault` (sticky) and enter HALT with `halted`=1.

Boundary conditions:
- `run` falling mid-FETCH or mid-ISSUE: the current frame completes fully, then the sequencer goes to IDLE. No request is abandoned.
- PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00.
- `zero_flag` is sampled only in the DECODE cycle.

## Timing
- Reset values: `pc`=`RESET_PC`; `imem_req`, `frame_valid`, `halted`, `fault` = 0; `frame`=17'h0; `imem_addr`=`RESET_PC`; state IDLE.
- Reset takes effect at the first edge with `reset_n`=0, in any state. The outstanding fetch is dropped, and a late `imem_rvalid` is ignored.
- `run` high in IDLE at edge N: `imem_req`=1 after edge N.
- `imem_rvalid` at edge M: DECODE during cycle M+1; `frame_valid`=1 after edge M+1.
- Data-frame throughput with zero-wait memory and `frame_ready`=1: 1 frame per 4 cycles.
- Control frame: next `imem_req` rises the cycle after DECODE.
- All outputs are registered.

## Configuration
- `FRAME_SEQ_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - A single-cycle `step` pulse in IDLE while `run`=0 sequences exactly one frame (fetch, decode, issue or branch), then returns to IDLE.
  - `step` is ignored outside IDLE and while `run`=1.
- Not defined: no `step` port; only `run` starts sequencing.

## Structure
- Package `oak_pkg`:
  - `FRAME_W`=17, `PC_W`=8.
  - Opcode localparams `OP_NOP`..`OP_FLASH_ST`, `OP_JMP`=4'hC, `OP_JNE`=4'hD, `OP_JEQ`=4'hE, `OP_HALT`=4'hF.
  - Sequencer state enum typedef.
- One sub-module, `fetch_watchdog`: cycle counter with clear/enable inputs and an expired output.

## Test plan
- Program at 0x00–0x01 = {0x2_0A0.., 0x3_...}, zero-wait memory, `frame_ready`=1 → `frame_valid` pulses twice with those exact frames; `pc` 0x00→0x01→0x02.
- Frame at 0x05 = JMP, `frame[12:5]`=0x40 → next `imem_addr`=0x40; `frame_valid` never asserted for the JMP frame.
- JEQ to 0x10 at 0x07: `zero_flag`=1 → `imem_addr`=0x10; repeat with `zero_flag`=0 → `imem_addr`=0x08. JNE gives the inverse results.
- `frame_ready` held low 5 cycles → `frame` and `frame_valid` stable for all 5 cycles; `pc` increments only on the accepting edge. `pc`=0xFF data frame → `pc`=0x00.
- `imem_rvalid` withheld, `FETCH_TIMEOUT`=15 → `fault`=1 and `halted`=1 after 15 FETCH cycles. `reset_n`=0 for one edge → all outputs return to reset values.
- HALT frame → `halted`=1 and no further `imem_req`. With `FRAME_SEQ_STEP_EN`: `run`=0 plus one `step` pulse → exactly one `imem_req`/issue, then IDLE.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// rtl/frame_sequencer_pkg.sv - shared widths, opcodes and sequencer state type for oak832128
package oak_pkg;

   localparam int FRAME_W = 17;
   localparam int PC_W    = 8;

   localparam logic [3:0] OP_NOP      = 4'h0;
   localparam logic [3:0] OP_ADD      = 4'h1;
   localparam logic [3:0] OP_SUB      = 4'h2;
   localparam logic [3:0] OP_AND      = 4'h3;
   localparam logic [3:0] OP_OR       = 4'h4;
   localparam logic [3:0] OP_XOR      = 4'h5;
   localparam logic [3:0] OP_SHL      = 4'h6;
   localparam logic [3:0] OP_SHR      = 4'h7;
   localparam logic [3:0] OP_LD       = 4'h8;
   localparam logic [3:0] OP_ST       = 4'h9;
   localparam logic [3:0] OP_FLASH_LD = 4'hA;
   localparam logic [3:0] OP_FLASH_ST = 4'hB;
   localparam logic [3:0] OP_JMP      = 4'hC;
   localparam logic [3:0] OP_JNE      = 4'hD;
   localparam logic [3:0] OP_JEQ      = 4'hE;
   localparam logic [3:0] OP_HALT     = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_HALT
   } seq_state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - program-memory fetch and execute-core issue handshakes
interface frame_sequencer_if;
   import oak_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [FRAME_W-1:0] imem_rdata;
   logic               imem_rvalid;
   logic [FRAME_W-1:0] frame;
   logic               frame_valid;
   logic               frame_ready;

   modport master (
      output imem_req, imem_addr, frame, frame_valid,
      input  imem_rdata, imem_rvalid, frame_ready
   );

   modport slave (
      input  imem_req, imem_addr, frame, frame_valid,
      output imem_rdata, imem_rvalid, frame_ready
   );

endinterface

// File: rtl/frame_sequencer_fetch_watchdog.sv
// rtl/frame_sequencer_fetch_watchdog.sv - counts cycles spent waiting on a fetch response
module fetch_watchdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [15:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 16'd1;
      end
   end

   // Fires during the TIMEOUT-th enabled cycle so the caller can leave on that edge.
   generate
      if (TIMEOUT == 0) begin : g_off
         assign o_expired = 1'b0;
      end else begin : g_on
         assign o_expired = i_enable && (r_count == 16'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - fetch/decode/issue loop for oak832128; FRAME_SEQ_STEP_EN adds single-step input
module frame_sequencer
   import oak_pkg::*;
#(
   parameter logic [7:0]  RESET_PC      = 8'h00,
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic                sysclk,
   input  logic                reset_n,
   input  logic                run,
`ifdef FRAME_SEQ_STEP_EN
   input  logic                step,
`endif
   input  logic                zero_flag,
   frame_sequencer_if.master   bus,
   output logic [PC_W-1:0]     pc,
   output logic                halted,
   output logic                fault
);

   seq_state_t         r_state;
   seq_state_t         w_next_state;
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    w_next_pc;
   logic [PC_W-1:0]    w_pc_inc;
   logic [PC_W-1:0]    w_target;
   logic [3:0]         w_opcode;
   logic [FRAME_W-1:0] r_fetch_frame;
   logic [FRAME_W-1:0] r_frame;
   logic               r_imem_req;
   logic               r_frame_valid;
   logic               r_halted;
   logic               r_fault;
   logic               w_fault_set;
   logic               w_start;
   logic               w_expired;
   seq_state_t         w_resume;

`ifdef FRAME_SEQ_STEP_EN
   assign w_start = run || step;
`else
   assign w_start = run;
`endif

   assign w_pc_inc = r_pc + 8'd1;
   assign w_opcode = r_fetch_frame[16:13];
   assign w_target = r_fetch_frame[12:5];
   assign w_resume = run ? ST_FETCH : ST_IDLE;

   fetch_watchdog #(
      .TIMEOUT (FETCH_TIMEOUT)
   ) u_watchdog (
      .i_clk     (sysclk),
      .i_reset_n (reset_n),
      .i_clear   (r_state != ST_FETCH),
      .i_enable  (r_state == ST_FETCH),
      .o_expired (w_expired)
   );

   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_PC;
         r_fetch_frame <= '0;
         r_frame       <= '0;
         r_imem_req    <= 1'b0;
         r_frame_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_pc          <= w_next_pc;
         r_imem_req    <= (w_next_state == ST_FETCH);
         r_frame_valid <= (w_next_state == ST_ISSUE);
         r_halted      <= (w_next_state == ST_HALT);
         if (w_fault_set) begin
            r_fault <= 1'b1;
         end
         if (r_state == ST_FETCH && bus.imem_rvalid) begin
            r_fetch_frame <= bus.imem_rdata;
         end
         // Only data frames reach the core-facing register; control frames stay internal.
         if (r_state == ST_DECODE && w_next_state == ST_ISSUE) begin
            r_frame <= r_fetch_frame;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_fault_set  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_next_state = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.imem_rvalid) begin
               w_next_state = ST_DECODE;
            end else if (w_expired) begin
               w_next_state = ST_HALT;
               w_fault_set  = 1'b1;
            end
         end
         ST_DECODE: begin
            case (w_opcode)
               OP_JMP: begin
                  w_next_pc    = w_target;
                  w_next_state = w_resume;
               end
               OP_JNE: begin
                  w_next_pc    = zero_flag ? w_pc_inc : w_target;
                  w_next_state = w_resume;
               end
               OP_JEQ: begin
                  w_next_pc    = zero_flag ? w_target : w_pc_inc;
                  w_next_state = w_resume;
               end
               OP_HALT: w_next_state = ST_HALT;
               default: w_next_state = ST_ISSUE;
            endcase
         end
         ST_ISSUE: begin
            if (bus.frame_ready) begin
               w_next_pc    = w_pc_inc;
               w_next_state = w_resume;
            end
         end
         ST_HALT: w_next_state = ST_HALT;
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign bus.imem_req    = r_imem_req;
   assign bus.imem_addr   = r_pc;
   assign bus.frame       = r_frame;
   assign bus.frame_valid = r_frame_valid;
   assign pc              = r_pc;
   assign halted          = r_halted;
   assign fault           = r_fault;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer
module tb_frame_sequencer;

   logic sysclk = 1'b0;
   logic reset_n;
   logic run;
   logic step;
   logic zero_flag;
   logic [7:0] pc;
   logic halted;
   logic fault;
   logic mem_en;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ctrl_seen = 0;
   int t0;

   logic [16:0] mem [256];
   logic [7:0]  fetch_q [$];
   logic [16:0] acc_q [$];

   localparam logic [16:0] D0     = {4'h2, 13'h0A05};
   localparam logic [16:0] D1     = {4'h3, 13'h1234};
   localparam logic [16:0] D2     = {4'hB, 13'h0F0F};
   localparam logic [16:0] D3     = {4'h8, 13'h1ABC};
   localparam logic [16:0] HALT_F = {4'hF, 13'h0000};

   logic [7:0]  exp_a [9] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h40, 8'h41, 8'h07, 8'h10, 8'h11};
   logic [7:0]  exp_b [9] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h40, 8'h41, 8'h07, 8'h08, 8'h30};
   logic [16:0] exp_f [3] = '{D0, D1, D2};

   frame_sequencer_if bus_if ();

   frame_sequencer #(
      .RESET_PC      (8'h00),
      .FETCH_TIMEOUT (15)
   ) dut (
      .sysclk    (sysclk),
      .reset_n   (reset_n),
      .run       (run),
`ifdef FRAME_SEQ_STEP_EN
      .step      (step),
`endif
      .zero_flag (zero_flag),
      .bus       (bus_if),
      .pc        (pc),
      .halted    (halted),
      .fault     (fault)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   // Program memory answers one cycle after it sees a request.
   always @(posedge sysclk) begin
      bus_if.imem_rvalid <= mem_en && bus_if.imem_req && !bus_if.imem_rvalid;
      bus_if.imem_rdata  <= mem[bus_if.imem_addr];
   end

   always @(posedge sysclk) begin
      if (reset_n) begin
         if (bus_if.imem_req && bus_if.imem_rvalid) fetch_q.push_back(bus_if.imem_addr);
         if (bus_if.frame_valid && bus_if.frame_ready) acc_q.push_back(bus_if.frame);
         if (bus_if.frame_valid && bus_if.frame[16:13] >= 4'hC) ctrl_seen++;
      end
   end

   function automatic logic [16:0] ctl(input logic [3:0] op, input logic [7:0] tgt);
      return {op, tgt, 5'h00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (bus_if.frame_valid !== 1'b1 && n < 40) begin
         @(negedge sysclk);
         n++;
      end
      chk(tag, {31'h0, bus_if.frame_valid}, 32'h1);
   endtask

   task automatic wait_halted(input string tag);
      int n = 0;
      while (halted !== 1'b1 && n < 200) begin
         @(negedge sysclk);
         n++;
      end
      chk(tag, {31'h0, halted}, 32'h1);
   endtask

   task automatic do_reset();
      run     = 1'b0;
      reset_n = 1'b0;
      @(negedge sysclk);
      @(negedge sysclk);
      fetch_q.delete();
      acc_q.delete();
      ctrl_seen = 0;
      reset_n = 1'b1;
      @(negedge sysclk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pc"},    {24'h0, pc}, 32'h00);
      chk({tag, "_addr"},  {24'h0, bus_if.imem_addr}, 32'h00);
      chk({tag, "_req"},   {31'h0, bus_if.imem_req}, 32'h0);
      chk({tag, "_valid"}, {31'h0, bus_if.frame_valid}, 32'h0);
      chk({tag, "_frame"}, {15'h0, bus_if.frame}, 32'h0);
      chk({tag, "_halt"},  {31'h0, halted}, 32'h0);
      chk({tag, "_fault"}, {31'h0, fault}, 32'h0);
   endtask

   task automatic chk_fetches(input string tag, input logic [7:0] exp [9]);
      chk({tag, "_nfetch"}, fetch_q.size(), 32'd9);
      for (int i = 0; i < 9; i++)
         chk({tag, "_fetch"}, (i < fetch_q.size()) ? {24'h0, fetch_q[i]} : 32'hDEAD, {24'h0, exp[i]});
      chk({tag, "_nacc"}, acc_q.size(), 32'd3);
      for (int i = 0; i < 3; i++)
         chk({tag, "_acc"}, (i < acc_q.size()) ? {15'h0, acc_q[i]} : 32'hDEAD, {15'h0, exp_f[i]});
      chk({tag, "_ctrl"}, ctrl_seen, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; run = 1'b0; step = 1'b0; zero_flag = 1'b0; mem_en = 1'b1;
      bus_if.frame_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = HALT_F;
      mem[8'h00] = D0;
      mem[8'h01] = D1;
      mem[8'h02] = ctl(4'hC, 8'h05);
      mem[8'h05] = ctl(4'hC, 8'h40);
      mem[8'h40] = D2;
      mem[8'h41] = ctl(4'hC, 8'h07);
      mem[8'h07] = ctl(4'hE, 8'h10);
      mem[8'h10] = ctl(4'hD, 8'h20);
      mem[8'h08] = ctl(4'hD, 8'h30);

      do_reset();
      chk_reset_outputs("rst");

      // Program A: zero_flag=1 takes JEQ, falls through JNE
      zero_flag = 1'b1; bus_if.frame_ready = 1'b1; run = 1'b1;
      wait_valid("a_v0");
      t0 = cyc;
      chk("a_f0", {15'h0, bus_if.frame}, {15'h0, D0});
      chk("a_pc0", {24'h0, pc}, 32'h00);
      @(negedge sysclk);
      chk("a_pulse", {31'h0, bus_if.frame_valid}, 32'h0);
      wait_valid("a_v1");
      chk("a_f1", {15'h0, bus_if.frame}, {15'h0, D1});
      chk("a_pc1", {24'h0, pc}, 32'h01);
      chk("a_rate", cyc - t0, 32'd4);
      wait_halted("a_halt");
      chk("a_pch", {24'h0, pc}, 32'h11);
      repeat (5) @(negedge sysclk);
      chk("a_noreq", {31'h0, bus_if.imem_req}, 32'h0);
      chk("a_fault", {31'h0, fault}, 32'h0);
      chk_fetches("a", exp_a);

      // Program B: zero_flag=0 falls through JEQ, takes JNE
      do_reset();
      zero_flag = 1'b0; run = 1'b1;
      wait_halted("b_halt");
      chk("b_pch", {24'h0, pc}, 32'h30);
      chk_fetches("b", exp_b);

      // Back-pressure, then run dropped mid-FETCH
      do_reset();
      bus_if.frame_ready = 1'b0; run = 1'b1;
      wait_valid("s_v0");
      for (int i = 0; i < 5; i++) begin
         @(negedge sysclk);
         chk("s_valid", {31'h0, bus_if.frame_valid}, 32'h1);
         chk("s_frame", {15'h0, bus_if.frame}, {15'h0, D0});
         chk("s_pc", {24'h0, pc}, 32'h00);
      end
      bus_if.frame_ready = 1'b1;
      @(negedge sysclk);
      chk("s_pcacc", {24'h0, pc}, 32'h01);
      chk("s_fetch", {31'h0, bus_if.imem_req}, 32'h1);
      run = 1'b0;
      wait_valid("s_v1");
      chk("s_f1", {15'h0, bus_if.frame}, {15'h0, D1});
      @(negedge sysclk);
      chk("s_pc2", {24'h0, pc}, 32'h02);
      repeat (3) @(negedge sysclk);
      chk("s_idle", {31'h0, bus_if.imem_req}, 32'h0);
      chk("s_nfetch", fetch_q.size(), 32'd2);

      // PC wrap at 0xFF
      mem[8'h00] = ctl(4'hC, 8'hFF);
      mem[8'hFF] = D3;
      do_reset();
      run = 1'b1;
      wait_valid("w_v");
      chk("w_pcff", {24'h0, pc}, 32'hFF);
      chk("w_frame", {15'h0, bus_if.frame}, {15'h0, D3});
      run = 1'b0;
      @(negedge sysclk);
      chk("w_pc00", {24'h0, pc}, 32'h00);
      repeat (3) @(negedge sysclk);
      chk("w_idle", {31'h0, bus_if.imem_req}, 32'h0);
      mem[8'h00] = D0;

      // Fetch watchdog, then a single reset edge
      do_reset();
      mem_en = 1'b0; run = 1'b1;
      @(negedge sysclk);
      chk("t_req", {31'h0, bus_if.imem_req}, 32'h1);
      repeat (14) @(negedge sysclk);
      chk("t_early", {31'h0, fault}, 32'h0);
      @(negedge sysclk);
      chk("t_fault", {31'h0, fault}, 32'h1);
      chk("t_halt", {31'h0, halted}, 32'h1);
      chk("t_noreq", {31'h0, bus_if.imem_req}, 32'h0);
      mem_en = 1'b1; run = 1'b0; reset_n = 1'b0;
      @(negedge sysclk);
      reset_n = 1'b1;
      chk_reset_outputs("t_rst");

`ifdef FRAME_SEQ_STEP_EN
      do_reset();
      bus_if.frame_ready = 1'b1;
      step = 1'b1;
      @(negedge sysclk);
      step = 1'b0;
      repeat (12) @(negedge sysclk);
      chk("p_nacc", acc_q.size(), 32'd1);
      chk("p_nfetch", fetch_q.size(), 32'd1);
      chk("p_pc", {24'h0, pc}, 32'h01);
      chk("p_idle", {31'h0, bus_if.imem_req}, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
